// File: rtl/conv_pkg.sv
// Shared constants and types for the P-lane 3x3 convolution datapath:
// register map, control-field layout and the identity kernel used at reset.
package conv_pkg;

  localparam int NUM_TAPS = 9;

  localparam int ADDR_K00  = 0;
  localparam int ADDR_K01  = 1;
  localparam int ADDR_K02  = 2;
  localparam int ADDR_K10  = 3;
  localparam int ADDR_K11  = 4;
  localparam int ADDR_K12  = 5;
  localparam int ADDR_K20  = 6;
  localparam int ADDR_K21  = 7;
  localparam int ADDR_K22  = 8;
  localparam int ADDR_CTRL = 9;

  localparam int SHIFT_LSB = 0;
  localparam int SHIFT_W   = 4;
  localparam int ABS_BIT   = 4;

  localparam int ID_KERNEL [NUM_TAPS] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

  typedef struct packed {
    logic               absEn;
    logic [SHIFT_W-1:0] shift;
  } ctrl_t;

  // Accumulator width that can hold any 3x3 sum of (BITW+1)x(CW) products.
  function automatic int accWidth(int bitw, int cw);
    return bitw + cw + 5;
  endfunction

endpackage

// File: rtl/conv3x3_lane.sv
// One lane of the 3x3 convolution: multiply, row sums, total, then
// round/shift, optional abs and clamp to the pixel range.
module conv3x3_lane
  import conv_pkg::*;
#(
  parameter int BITW = 8,
  parameter int CW   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_TAPS*BITW-1:0] taps_i,
  input  logic [NUM_TAPS*CW-1:0]   coef_i,
  input  logic [SHIFT_W-1:0]       shift_i,
  input  logic                     absEn_i,
  input  logic                     valid_i,
  output logic [BITW-1:0]          pix_o,
  output logic                     valid_o,
  output logic                     sat_o
);

  localparam int ACCW = accWidth(BITW, CW);
  localparam int PW   = BITW + CW + 1;
  localparam int RW   = BITW + CW + 3;
  localparam int SHW  = $clog2(ACCW);
  localparam logic signed [ACCW:0] PIX_MAX = (ACCW+1)'((1 << BITW) - 1);

  logic signed [PW-1:0]   prod_d [NUM_TAPS];
  logic signed [PW-1:0]   prod_q [NUM_TAPS];
  logic signed [RW-1:0]   rowSum_d [3];
  logic signed [RW-1:0]   rowSum_q [3];
  logic signed [ACCW-1:0] total_d, total_q;
  logic signed [ACCW:0]   rounded, scaled_d, scaled_q, mag;
  logic [SHW-1:0]         shiftS1_d, shiftS1_q, shiftS2_q, shiftS3_q;
  logic                   absS1_q, absS2_q, absS3_q, absS4_q;
  logic                   validS1_q, validS2_q, validS3_q, validS4_q;
  logic [BITW-1:0]        pix_d, pix_q;
  logic                   sat_d, sat_q, validOut_q;

  // Taps are unsigned pixels, so a zero MSB makes them safe signed operands.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      prod_d[k] = PW'($signed({1'b0, taps_i[k*BITW +: BITW]})) *
                  PW'($signed(coef_i[k*CW +: CW]));
    end
    if (int'(shift_i) > ACCW - 1) shiftS1_d = SHW'(ACCW - 1);
    else                          shiftS1_d = SHW'(shift_i);
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      rowSum_d[r] = RW'(prod_q[3*r]) + RW'(prod_q[3*r+1]) + RW'(prod_q[3*r+2]);
    end
    total_d = ACCW'(rowSum_q[0]) + ACCW'(rowSum_q[1]) + ACCW'(rowSum_q[2]);
  end

  // One extra bit of headroom so the rounding offset can never wrap.
  always_comb begin
    rounded = (ACCW+1)'(total_q);
    if (shiftS3_q != '0) rounded = rounded + ((ACCW+1)'(1) << (shiftS3_q - SHW'(1)));
    scaled_d = rounded >>> shiftS3_q;
  end

  always_comb begin
    mag = scaled_q;
    if (absS4_q && scaled_q[ACCW]) mag = -scaled_q;
    pix_d = mag[BITW-1:0];
    sat_d = 1'b0;
    if (mag[ACCW]) begin
      pix_d = '0;
      sat_d = 1'b1;
    end else if (mag > PIX_MAX) begin
      pix_d = '1;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= '0;
      for (int r = 0; r < 3; r++) rowSum_q[r] <= '0;
      total_q    <= '0;
      scaled_q   <= '0;
      shiftS1_q  <= '0;
      shiftS2_q  <= '0;
      shiftS3_q  <= '0;
      absS1_q    <= 1'b0;
      absS2_q    <= 1'b0;
      absS3_q    <= 1'b0;
      absS4_q    <= 1'b0;
      validS1_q  <= 1'b0;
      validS2_q  <= 1'b0;
      validS3_q  <= 1'b0;
      validS4_q  <= 1'b0;
      pix_q      <= '0;
      sat_q      <= 1'b0;
      validOut_q <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      rowSum_q   <= rowSum_d;
      total_q    <= total_d;
      scaled_q   <= scaled_d;
      shiftS1_q  <= shiftS1_d;
      shiftS2_q  <= shiftS1_q;
      shiftS3_q  <= shiftS2_q;
      absS1_q    <= absEn_i;
      absS2_q    <= absS1_q;
      absS3_q    <= absS2_q;
      absS4_q    <= absS3_q;
      validS1_q  <= valid_i;
      validS2_q  <= validS1_q;
      validS3_q  <= validS2_q;
      validS4_q  <= validS3_q;
      pix_q      <= pix_d;
      sat_q      <= sat_d;
      validOut_q <= validS4_q;
    end
  end

  assign pix_o   = pix_q;
  assign sat_o   = sat_q;
  assign valid_o = validOut_q;

endmodule

// File: rtl/conv3x3_mac_p.sv
// P-lane 3x3 convolution: shadow/active kernel banks feeding P independent
// lane pipelines; commit swaps the whole bank between two windows.
module conv3x3_mac_p
  import conv_pkg::*;
#(
  parameter int BITW = 8,
  parameter int P    = 4,
  parameter int CW   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [P*BITW-1:0] w00,
  input  logic [P*BITW-1:0] w01,
  input  logic [P*BITW-1:0] w02,
  input  logic [P*BITW-1:0] w10,
  input  logic [P*BITW-1:0] w11,
  input  logic [P*BITW-1:0] w12,
  input  logic [P*BITW-1:0] w20,
  input  logic [P*BITW-1:0] w21,
  input  logic [P*BITW-1:0] w22,
  input  logic [P-1:0]      win_valid_vec,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [15:0]       cfg_wdata,
  input  logic              cfg_commit,
  output logic [P*BITW-1:0] out_pix_vec,
  output logic [P-1:0]      out_valid_vec,
  output logic [P-1:0]      out_sat_vec
);

  logic signed [CW-1:0] kShadow_d [NUM_TAPS];
  logic signed [CW-1:0] kShadow_q [NUM_TAPS];
  logic signed [CW-1:0] kActive_d [NUM_TAPS];
  logic signed [CW-1:0] kActive_q [NUM_TAPS];
  ctrl_t                ctrlShadow_d, ctrlShadow_q, ctrlActive_d, ctrlActive_q;
  logic [NUM_TAPS*CW-1:0] kActiveFlat;
  logic                 unusedWdata;

  assign unusedWdata = ^cfg_wdata;

  // Commit copies the pre-write shadow, so a same-cycle write needs a second commit.
  always_comb begin
    kShadow_d    = kShadow_q;
    kActive_d    = kActive_q;
    ctrlShadow_d = ctrlShadow_q;
    ctrlActive_d = ctrlActive_q;
    if (cfg_commit) begin
      kActive_d    = kShadow_q;
      ctrlActive_d = ctrlShadow_q;
    end
    if (cfg_we) begin
      if (int'(cfg_addr) <= ADDR_K22) begin
        kShadow_d[cfg_addr] = cfg_wdata[CW-1:0];
      end else if (int'(cfg_addr) == ADDR_CTRL) begin
        ctrlShadow_d.shift = cfg_wdata[SHIFT_LSB +: SHIFT_W];
        ctrlShadow_d.absEn = cfg_wdata[ABS_BIT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        kShadow_q[k] <= CW'(ID_KERNEL[k]);
        kActive_q[k] <= CW'(ID_KERNEL[k]);
      end
      ctrlShadow_q <= '0;
      ctrlActive_q <= '0;
    end else begin
      kShadow_q    <= kShadow_d;
      kActive_q    <= kActive_d;
      ctrlShadow_q <= ctrlShadow_d;
      ctrlActive_q <= ctrlActive_d;
    end
  end

  always_comb begin
    kActiveFlat = '0;
    for (int k = 0; k < NUM_TAPS; k++) kActiveFlat[k*CW +: CW] = kActive_q[k];
  end

  for (genvar i = 0; i < P; i++) begin : gLane
    logic [NUM_TAPS*BITW-1:0] laneTaps;

    assign laneTaps = {w22[i*BITW +: BITW], w21[i*BITW +: BITW], w20[i*BITW +: BITW],
                       w12[i*BITW +: BITW], w11[i*BITW +: BITW], w10[i*BITW +: BITW],
                       w02[i*BITW +: BITW], w01[i*BITW +: BITW], w00[i*BITW +: BITW]};

    conv3x3_lane #(
      .BITW(BITW),
      .CW  (CW)
    ) uLane (
      .clk    (clk),
      .rst_n  (rst_n),
      .taps_i (laneTaps),
      .coef_i (kActiveFlat),
      .shift_i(ctrlActive_q.shift),
      .absEn_i(ctrlActive_q.absEn),
      .valid_i(win_valid_vec[i]),
      .pix_o  (out_pix_vec[i*BITW +: BITW]),
      .valid_o(out_valid_vec[i]),
      .sat_o  (out_sat_vec[i])
    );
  end

endmodule

// File: tb/tb_conv3x3_mac_p.sv
// Self-checking bench for conv3x3_mac_p: random windows and config traffic
// against an arithmetic reference model, plus hand-computed directed cases.
module tb_conv3x3_mac_p;

  localparam int BITW = 8;
  localparam int P    = 4;
  localparam int CW   = 8;
  localparam int ACCW = BITW + CW + 5;
  localparam int LAT  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [P*BITW-1:0] w [9];
  logic [P-1:0]      win_valid_vec;
  logic              cfg_we, cfg_commit;
  logic [3:0]        cfg_addr;
  logic [15:0]       cfg_wdata;
  logic [P*BITW-1:0] out_pix_vec;
  logic [P-1:0]      out_valid_vec, out_sat_vec;

  int nTests = 0;
  int nFails = 0;
  bit checkEn = 1'b0;

  conv3x3_mac_p #(.BITW(BITW), .P(P), .CW(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .w00          (w[0]),
    .w01          (w[1]),
    .w02          (w[2]),
    .w10          (w[3]),
    .w11          (w[4]),
    .w12          (w[5]),
    .w20          (w[6]),
    .w21          (w[7]),
    .w22          (w[8]),
    .win_valid_vec(win_valid_vec),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_commit   (cfg_commit),
    .out_pix_vec  (out_pix_vec),
    .out_valid_vec(out_valid_vec),
    .out_sat_vec  (out_sat_vec)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [P-1:0]      v;
    logic [P*BITW-1:0] pix;
    logic [P-1:0]      sat;
  } exp_t;

  exp_t line [LAT];
  exp_t expOut;
  int   mShK [9];
  int   mAcK [9];
  int   mShShift, mAcShift;
  bit   mShAbs, mAcAbs;

  // Expected result of the current window under the model's active bank.
  function automatic exp_t modelWindow();
    exp_t   e;
    longint acc;
    int     s;
    e.v   = win_valid_vec;
    e.pix = '0;
    e.sat = '0;
    s = (mAcShift > ACCW - 1) ? ACCW - 1 : mAcShift;
    for (int l = 0; l < P; l++) begin
      acc = 0;
      for (int k = 0; k < 9; k++) acc += longint'(mAcK[k]) * longint'(w[k][l*BITW +: BITW]);
      if (s > 0) acc = (acc + (longint'(1) << (s - 1))) >>> s;
      if (mAcAbs && acc < 0) acc = -acc;
      if (acc < 0) begin
        e.pix[l*BITW +: BITW] = '0;
        e.sat[l] = 1'b1;
      end else if (acc > 255) begin
        e.pix[l*BITW +: BITW] = '1;
        e.sat[l] = 1'b1;
      end else begin
        e.pix[l*BITW +: BITW] = BITW'(acc);
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) line[i] <= '0;
      expOut <= '0;
      for (int k = 0; k < 9; k++) begin
        mShK[k] <= (k == 4) ? 1 : 0;
        mAcK[k] <= (k == 4) ? 1 : 0;
      end
      mShShift <= 0;
      mAcShift <= 0;
      mShAbs   <= 1'b0;
      mAcAbs   <= 1'b0;
    end else begin
      expOut  <= line[LAT-1];
      for (int i = LAT - 1; i > 0; i--) line[i] <= line[i-1];
      line[0] <= modelWindow();
      if (cfg_commit) begin
        mAcK     <= mShK;
        mAcShift <= mShShift;
        mAcAbs   <= mShAbs;
      end
      if (cfg_we) begin
        if (cfg_addr < 4'd9) mShK[cfg_addr] <= int'($signed(cfg_wdata[CW-1:0]));
        else if (cfg_addr == 4'd9) begin
          mShShift <= int'(cfg_wdata[3:0]);
          mShAbs   <= cfg_wdata[4];
        end
      end
    end
  end

  // Every cycle: valid vector always, pixel and sat only on valid lanes.
  always @(negedge clk) begin
    if (checkEn) begin
      nTests++;
      if (out_valid_vec !== expOut.v) begin
        nFails++;
        $display("[TB] FAIL valid @%0t: got %b expected %b", $time, out_valid_vec, expOut.v);
      end
      for (int l = 0; l < P; l++) begin
        if (expOut.v[l]) begin
          nTests++;
          if (out_pix_vec[l*BITW +: BITW] !== expOut.pix[l*BITW +: BITW] ||
              out_sat_vec[l] !== expOut.sat[l]) begin
            nFails++;
            $display("[TB] FAIL lane%0d @%0t: got pix=%0d sat=%b expected pix=%0d sat=%b",
                     l, $time, out_pix_vec[l*BITW +: BITW], out_sat_vec[l],
                     expOut.pix[l*BITW +: BITW], expOut.sat[l]);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [P*BITW-1:0] expPix,
                             input logic [P-1:0] expSat, input logic [P-1:0] expValid);
    nTests++;
    if (out_pix_vec !== expPix || out_sat_vec !== expSat || out_valid_vec !== expValid) begin
      nFails++;
      $display("[TB] FAIL %s: got pix=%h sat=%b valid=%b expected pix=%h sat=%b valid=%b",
               name, out_pix_vec, out_sat_vec, out_valid_vec, expPix, expSat, expValid);
    end
    nTests++;
    if (expOut.pix !== expPix || expOut.sat !== expSat || expOut.v !== expValid) begin
      nFails++;
      $display("[TB] FAIL %s model: got pix=%h sat=%b valid=%b expected pix=%h sat=%b valid=%b",
               name, expOut.pix, expOut.sat, expOut.v, expPix, expSat, expValid);
    end
  endtask

  task automatic applyStimulus(input int n, input bit allValid, input bit cfgTraffic);
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < 9; k++) w[k] = $urandom;
      win_valid_vec = allValid ? '1 : P'($urandom);
      cfg_we     = 1'b0;
      cfg_commit = 1'b0;
      if (cfgTraffic) begin
        if ($urandom_range(0, 3) == 0) begin
          cfg_we    = 1'b1;
          cfg_addr  = 4'($urandom);
          cfg_wdata = 16'($urandom);
        end
        if ($urandom_range(0, 7) == 0) cfg_commit = 1'b1;
      end
    end
    @(negedge clk);
    cfg_we        = 1'b0;
    cfg_commit    = 1'b0;
    win_valid_vec = '0;
  endtask

  task automatic cfgWrite(input int a, input int d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 4'(a);
    cfg_wdata = 16'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic commitBank();
    @(negedge clk);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic setKernel(input int k [9], input int ctrl);
    for (int i = 0; i < 9; i++) cfgWrite(i, k[i]);
    cfgWrite(9, ctrl);
    commitBank();
  endtask

  // Hold one window for the whole latency, then compare against literals.
  task automatic directedWindow(input string name, input int tapVal [9],
                                input int expPix, input bit expSat);
    @(negedge clk);
    for (int k = 0; k < 9; k++) w[k] = {P{BITW'(tapVal[k])}};
    win_valid_vec = '1;
    repeat (LAT + 1) @(negedge clk);
    checkOutput(name, {P{BITW'(expPix)}}, expSat ? '1 : '0, '1);
    win_valid_vec = '0;
  endtask

  task automatic identityCheck(input string name);
    @(negedge clk);
    for (int k = 0; k < 9; k++) w[k] = $urandom;
    for (int l = 0; l < P; l++) w[4][l*BITW +: BITW] = BITW'(10 + 7 * l);
    win_valid_vec = '1;
    repeat (LAT + 1) @(negedge clk);
    checkOutput(name, w[4], '0, '1);
    win_valid_vec = '0;
  endtask

  int boxK   [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
  int sobelK [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int tap16  [9] = '{16, 16, 16, 16, 16, 16, 16, 16, 16};
  int tap20  [9] = '{20, 20, 20, 20, 20, 20, 20, 20, 20};
  int sobR   [9] = '{0, 50, 100, 0, 50, 100, 0, 50, 100};
  int sobL   [9] = '{100, 50, 0, 100, 50, 0, 100, 50, 0};

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 9; k++) w[k] = '0;
    win_valid_vec = '0;
    cfg_we        = 1'b0;
    cfg_commit    = 1'b0;
    cfg_addr      = '0;
    cfg_wdata     = '0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("reset", '0, '0, '0);
    rst_n = 1'b1;

    identityCheck("identity");
    applyStimulus(20, 1'b0, 1'b0);

    setKernel(boxK, 3);
    directedWindow("box16", tap16, 18, 1'b0);
    directedWindow("box20", tap20, 23, 1'b0);

    setKernel(sobelK, 0);
    directedWindow("sobel_pos", sobR, 255, 1'b1);
    directedWindow("sobel_neg", sobL, 0, 1'b1);
    cfgWrite(9, 16);
    commitBank();
    directedWindow("sobel_abs", sobL, 255, 1'b1);

    applyStimulus(200, 1'b0, 1'b1);

    // Stream while rewriting the shadow bank, then commit mid-stream.
    applyStimulus(5, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      for (int k = 0; k < 9; k++) w[k] = $urandom;
      win_valid_vec = '1;
      cfg_we     = (i < 10);
      cfg_addr   = 4'(i);
      cfg_wdata  = (i == 9) ? 16'($urandom_range(0, 4)) : 16'($urandom_range(0, 6) - 3);
      cfg_commit = (i == 10);
    end
    applyStimulus(8, 1'b1, 1'b0);

    // Same-cycle write and commit: the write only lands on the second commit.
    @(negedge clk);
    for (int k = 0; k < 9; k++) w[k] = $urandom;
    win_valid_vec = '1;
    cfg_we     = 1'b1;
    cfg_addr   = 4'd4;
    cfg_wdata  = 16'd7;
    cfg_commit = 1'b1;
    applyStimulus(8, 1'b1, 1'b0);
    commitBank();
    applyStimulus(8, 1'b1, 1'b0);

    @(negedge clk);
    win_valid_vec = 4'b0011;
    @(negedge clk);
    win_valid_vec = 4'b0000;
    @(negedge clk);
    win_valid_vec = 4'b1111;
    @(negedge clk);
    win_valid_vec = 4'b0000;
    repeat (LAT + 1) @(negedge clk);

    applyStimulus(3, 1'b1, 1'b0);
    @(negedge clk);
    win_valid_vec = '1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    win_valid_vec = '0;
    checkOutput("mid_reset", '0, '0, '0);
    repeat (LAT + 2) @(negedge clk);
    identityCheck("identity_after_reset");
    applyStimulus(30, 1'b0, 1'b0);

    repeat (LAT + 2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule
